// File: rtl/traffic_conflict_monitor_if.sv
// Bundle of lamp drives, timebase, mode and acknowledge inputs plus the
// fault outputs of the traffic conflict monitor.
//   master : the controller / environment side (drives lamps, ptick, ptest, pack)
//   slave  : the monitor side (drives pfcode, pfault, pflash, pnfault)
interface traffic_conflict_monitor_if;
    logic       pgrn1;
    logic       pylw1;
    logic       pred1;
    logic       pgrn2;
    logic       pylw2;
    logic       pred2;
    logic       ptick;
    logic       ptest;
    logic       pack;
    logic [4:0] pfcode;
    logic       pfault;
    logic       pflash;
    logic [7:0] pnfault;

    modport master (
        output pgrn1, pylw1, pred1, pgrn2, pylw2, pred2, ptick, ptest, pack,
        input  pfcode, pfault, pflash, pnfault
    );

    modport slave (
        input  pgrn1, pylw1, pred1, pgrn2, pylw2, pred2, ptick, ptest, pack,
        output pfcode, pfault, pflash, pnfault
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Traffic-light conflict monitor for a two-road intersection.
// Tracks each road's lamp state (RED/GRN/YLW), and latches sticky faults:
//   pfcode[0] conflict, [1] invalid lamp pattern, [2] illegal sequence,
//   [3] short yellow, [4] stall (no lamp-state change for WDOG ticks).
// Ports:
//   clock  : single clock, rising edge
//   pclr   : asynchronous active-high reset
//   bus    : slave modport -- lamp drives, ptick, ptest, pack in;
//            pfcode, pfault, pflash (= pfault), pnfault (saturating count of
//            fault-set events) out
module traffic_conflict_monitor #(
    parameter int unsigned MIN_YLW = 3,
    parameter int unsigned WDOG    = 1000
) (
    input  logic                        clock,
    input  logic                        pclr,
    traffic_conflict_monitor_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RED = 2'd0,
        ST_GRN = 2'd1,
        ST_YLW = 2'd2
    } road_st_t;

    localparam logic [7:0]  MIN_YLW_L = 8'(MIN_YLW);
    localparam logic [15:0] WDOG_L    = 16'(WDOG);

    logic [5:0]  lamp_all;
    logic [1:0]  inv_vec;
    logic [1:0]  nonred_vec;
    logic [1:0]  seq_vec;
    logic [1:0]  short_vec;
    logic [1:0]  chg_vec;

    logic        armed_reg;
    logic [15:0] wdog_reg, wdog_next;
    logic        stall_set;
    logic [4:0]  set_vec;
    logic [4:0]  code_reg, code_next;
    logic        fault_reg, fault_next;
    logic [7:0]  cnt_reg, cnt_next;

    assign lamp_all = {bus.pgrn2, bus.pylw2, bus.pred2,
                       bus.pgrn1, bus.pylw1, bus.pred1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_road
            logic [2:0] lamp;
            road_st_t   dec;
            road_st_t   trk_reg, trk_next;
            logic       dec_valid;
            logic       legal;
            logic [7:0] ycnt_reg;

            assign lamp = lamp_all[gi*3 +: 3];

            always_comb begin
                dec       = ST_RED;
                dec_valid = 1'b1;
                case (lamp)
                    3'b100:  dec = ST_GRN;
                    3'b010:  dec = ST_YLW;
                    3'b001:  dec = ST_RED;
                    default: dec_valid = 1'b0;
                endcase
            end

            always_comb begin
                legal = (dec == trk_reg)
                     || (trk_reg == ST_RED && dec == ST_GRN)
                     || (trk_reg == ST_GRN && dec == ST_YLW)
                     || (trk_reg == ST_YLW && dec == ST_RED);
                // An invalid pattern holds the tracked state; an illegal but
                // valid decode is still followed so tracking stays in step.
                trk_next = dec_valid ? dec : trk_reg;
            end

            assign inv_vec[gi]    = ~dec_valid;
            assign nonred_vec[gi] = dec_valid && (dec != ST_RED);
            // No sequence check on the arming edge: the first decode after
            // reset simply initialises the tracked state.
            assign seq_vec[gi]    = armed_reg && dec_valid && !legal;
            assign short_vec[gi]  = (trk_reg == ST_YLW) && dec_valid && (dec == ST_RED)
                                 && (ycnt_reg < MIN_YLW_L) && !bus.ptest;
            assign chg_vec[gi]    = (trk_next != trk_reg);

            always_ff @(posedge clock or posedge pclr) begin
                if (pclr) begin
                    trk_reg  <= ST_RED;
                    ycnt_reg <= 8'd0;
                end else begin
                    trk_reg <= trk_next;
                    if (trk_next == ST_YLW && trk_reg != ST_YLW) begin
                        ycnt_reg <= 8'd0;
                    end else if (trk_reg == ST_YLW && bus.ptick && ycnt_reg != 8'hFF) begin
                        ycnt_reg <= ycnt_reg + 8'd1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        wdog_next = wdog_reg;
        stall_set = 1'b0;
        if (|chg_vec) begin
            wdog_next = 16'd0;
        end else if (bus.ptick && wdog_reg != 16'hFFFF) begin
            wdog_next = wdog_reg + 16'd1;
            // Stall fires on the tick that brings the count to WDOG, so an
            // acknowledge with ptick idle can clear it.
            stall_set = (wdog_next == WDOG_L) && !bus.ptest;
        end

        set_vec = {stall_set, |short_vec, |seq_vec, |inv_vec, &nonred_vec};

        // Acknowledge clears everything first; a set in the same edge wins.
        code_next  = (code_reg & ~{5{bus.pack}}) | set_vec;
        fault_next = |code_next;

        cnt_next = cnt_reg;
        if ((|(code_next & ~code_reg)) && cnt_reg != 8'hFF) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge pclr) begin
        if (pclr) begin
            armed_reg <= 1'b0;
            wdog_reg  <= 16'd0;
            code_reg  <= 5'd0;
            fault_reg <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            armed_reg <= 1'b1;
            wdog_reg  <= wdog_next;
            code_reg  <= code_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.pfcode  = code_reg;
    assign bus.pfault  = fault_reg;
    assign bus.pflash  = fault_reg;
    assign bus.pnfault = cnt_reg;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;
    localparam int MIN_YLW = 3;
    localparam int WDOG    = 5;

    logic clock = 1'b0;
    logic pclr  = 1'b0;

    traffic_conflict_monitor_if bus();

    traffic_conflict_monitor #(.MIN_YLW(MIN_YLW), .WDOG(WDOG)) dut (
        .clock (clock),
        .pclr  (pclr),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: road states 0=RED 1=GRN 2=YLW; legal step is +1 mod 3.
    int         m_trk  [2];
    int         m_ycnt [2];
    int         m_wd;
    bit         m_armed;
    logic [4:0] m_code;
    int         m_cnt;

    function automatic int decode(input logic [2:0] gyr);
        if (gyr == 3'b100) return 1;
        if (gyr == 3'b010) return 2;
        if (gyr == 3'b001) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_trk[i]  = 0;
            m_ycnt[i] = 0;
        end
        m_wd    = 0;
        m_armed = 0;
        m_code  = 5'd0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        int d [2];
        int nt [2];
        logic [4:0] s;
        logic [4:0] old;
        bit chg;
        d[0] = decode({bus.pgrn1, bus.pylw1, bus.pred1});
        d[1] = decode({bus.pgrn2, bus.pylw2, bus.pred2});
        s = 5'd0;
        if (d[0] < 0 || d[1] < 0) s[1] = 1'b1;
        if (d[0] > 0 && d[1] > 0) s[0] = 1'b1;
        chg = 0;
        for (int i = 0; i < 2; i++) begin
            nt[i] = (d[i] < 0) ? m_trk[i] : d[i];
            if (m_armed && d[i] >= 0 && d[i] != m_trk[i] && d[i] != (m_trk[i] + 1) % 3)
                s[2] = 1'b1;
            if (m_trk[i] == 2 && d[i] == 0 && m_ycnt[i] < MIN_YLW && !bus.ptest)
                s[3] = 1'b1;
            if (nt[i] == 2 && m_trk[i] != 2)
                m_ycnt[i] = 0;
            else if (m_trk[i] == 2 && bus.ptick && m_ycnt[i] < 255)
                m_ycnt[i] = m_ycnt[i] + 1;
            if (nt[i] != m_trk[i]) chg = 1;
        end
        if (chg) begin
            m_wd = 0;
        end else if (bus.ptick && m_wd < 65535) begin
            m_wd = m_wd + 1;
            if (m_wd == WDOG && !bus.ptest) s[4] = 1'b1;
        end
        old    = m_code;
        m_code = (bus.pack ? 5'd0 : m_code) | s;
        if ((m_code & ~old) != 5'd0 && m_cnt < 255) m_cnt = m_cnt + 1;
        m_trk[0] = nt[0];
        m_trk[1] = nt[1];
        m_armed  = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_code"},  32'(bus.pfcode),  32'(m_code));
        chk({tag, "_fault"}, 32'(bus.pfault),  32'(|m_code));
        chk({tag, "_flash"}, 32'(bus.pflash),  32'(|m_code));
        chk({tag, "_cnt"},   32'(bus.pnfault), 32'(m_cnt));
    endtask

    // 0=RED 1=GRN 2=YLW 3=GRN+YLW (invalid)
    function automatic logic [2:0] lamp_bits(input int c);
        case (c)
            0:       return 3'b001;
            1:       return 3'b100;
            2:       return 3'b010;
            default: return 3'b110;
        endcase
    endfunction

    task automatic set_raw(input logic [2:0] a, input logic [2:0] b);
        {bus.pgrn1, bus.pylw1, bus.pred1} = a;
        {bus.pgrn2, bus.pylw2, bus.pred2} = b;
    endtask

    task automatic set_lamps(input int a, input int b);
        set_raw(lamp_bits(a), lamp_bits(b));
    endtask

    task automatic cyc(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
        $display("%-10s t=%0t l1=%b%b%b l2=%b%b%b tk=%0d ts=%0d ak=%0d code=%b cnt=%0d",
                 tag, $time, bus.pgrn1, bus.pylw1, bus.pred1, bus.pgrn2, bus.pylw2,
                 bus.pred2, bus.ptick, bus.ptest, bus.pack, bus.pfcode, bus.pnfault);
    endtask

    initial begin
        set_lamps(0, 0);
        bus.ptick = 1'b0;
        bus.ptest = 1'b0;
        bus.pack  = 1'b0;
        model_reset();

        // Reset state
        #1 pclr = 1'b1;
        #2;
        chk("rst_code",  32'(bus.pfcode),  32'h0);
        chk("rst_flash", 32'(bus.pflash),  32'h0);
        chk("rst_cnt",   32'(bus.pnfault), 32'h0);
        @(negedge clock);
        pclr = 1'b0;
        cyc("arm");

        // Legal full cycle on both roads
        set_lamps(1, 0); cyc("leg_g1");
        set_lamps(2, 0); cyc("leg_y1");
        bus.ptick = 1'b1;
        for (int i = 0; i < 4; i++) cyc("leg_y1t");
        bus.ptick = 1'b0;
        set_lamps(0, 0); cyc("leg_r1");
        set_lamps(0, 1); cyc("leg_g2");
        set_lamps(0, 2); cyc("leg_y2");
        bus.ptick = 1'b1;
        for (int i = 0; i < 4; i++) cyc("leg_y2t");
        bus.ptick = 1'b0;
        set_lamps(0, 0); cyc("leg_r2");
        chk("legal_code", 32'(bus.pfcode),  32'h0);
        chk("legal_cnt",  32'(bus.pnfault), 32'h0);

        // Conflict
        set_lamps(1, 1); cyc("conf");
        chk("conf_code",  32'(bus.pfcode),  32'h01);
        chk("conf_flash", 32'(bus.pflash),  32'h1);
        chk("conf_cnt",   32'(bus.pnfault), 32'h1);
        for (int i = 0; i < 10; i++) cyc("conf_hold");
        chk("conf_hold_cnt", 32'(bus.pnfault), 32'h1);
        set_lamps(2, 2); cyc("conf_y");
        bus.ptest = 1'b1;
        set_lamps(0, 0); cyc("conf_r");
        bus.ptest = 1'b0;
        bus.pack  = 1'b1; cyc("conf_ack");
        bus.pack  = 1'b0;
        chk("conf_ack_code", 32'(bus.pfcode), 32'h0);

        // Short yellow, then the same with test mode
        set_lamps(1, 0); cyc("sy_g");
        set_lamps(2, 0); cyc("sy_y");
        bus.ptick = 1'b1;
        cyc("sy_t"); cyc("sy_t");
        bus.ptick = 1'b0;
        set_lamps(0, 0); cyc("sy_r");
        chk("short_code", 32'(bus.pfcode), 32'h08);
        bus.pack = 1'b1; cyc("sy_ack");
        bus.pack = 1'b0;
        bus.ptest = 1'b1;
        set_lamps(1, 0); cyc("syt_g");
        set_lamps(2, 0); cyc("syt_y");
        bus.ptick = 1'b1;
        cyc("syt_t"); cyc("syt_t");
        bus.ptick = 1'b0;
        set_lamps(0, 0); cyc("syt_r");
        chk("short_test_code", 32'(bus.pfcode), 32'h0);
        bus.ptest = 1'b0;

        // Sequence fault, then ack while invalid
        set_lamps(1, 0); cyc("seq_g");
        set_lamps(0, 0); cyc("seq_r");
        chk("seq_code", 32'(bus.pfcode), 32'h04);
        set_lamps(3, 0); bus.pack = 1'b1; cyc("seq_ack_inv");
        chk("seq_ack_code", 32'(bus.pfcode), 32'h02);
        set_lamps(0, 0); cyc("seq_clr");
        bus.pack = 1'b0;

        // Watchdog stall
        bus.ptick = 1'b1;
        for (int i = 0; i < 4; i++) cyc("wd_t");
        chk("wd_pre_code", 32'(bus.pfcode), 32'h0);
        cyc("wd_t5");
        chk("wd_code", 32'(bus.pfcode), 32'h10);
        bus.ptick = 1'b0;
        bus.pack  = 1'b1; cyc("wd_ack");
        bus.pack  = 1'b0;
        chk("wd_ack_code", 32'(bus.pfcode), 32'h0);

        // Fault counter saturation
        for (int i = 0; i < 260; i++) begin
            set_lamps(1, 1); cyc("sat_set");
            set_lamps(0, 0); bus.pack = 1'b1; cyc("sat_ack");
            bus.pack = 1'b0;
        end
        chk("sat_cnt", 32'(bus.pnfault), 32'hFF);
        bus.pack = 1'b1; cyc("pre_all_ack");
        bus.pack = 1'b0;

        // All five faults latched, then asynchronous reset between edges
        set_lamps(2, 0); cyc("all_y");
        set_lamps(0, 0); cyc("all_r");
        set_lamps(1, 1); cyc("all_conf");
        set_lamps(3, 1); cyc("all_inv");
        bus.ptick = 1'b1;
        for (int i = 0; i < 5; i++) cyc("all_t");
        bus.ptick = 1'b0;
        chk("all_code", 32'(bus.pfcode), 32'h1F);
        @(negedge clock);
        #2 pclr = 1'b1;
        #1;
        chk("arst_code",  32'(bus.pfcode),  32'h0);
        chk("arst_fault", 32'(bus.pfault),  32'h0);
        chk("arst_flash", 32'(bus.pflash),  32'h0);
        chk("arst_cnt",   32'(bus.pnfault), 32'h0);
        model_reset();
        set_lamps(1, 0);
        @(negedge clock);
        pclr = 1'b0;
        cyc("rearm_g");
        chk("rearm_code", 32'(bus.pfcode), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                logic [2:0] bits;
                if ($urandom_range(0, 9) == 0) bits = 3'($urandom_range(0, 7));
                else bits = lamp_bits($urandom_range(0, 2));
                if (r == 0) {bus.pgrn1, bus.pylw1, bus.pred1} = bits;
                else        {bus.pgrn2, bus.pylw2, bus.pred2} = bits;
            end
            bus.ptick = 1'($urandom_range(0, 1));
            bus.ptest = ($urandom_range(0, 7) == 0);
            bus.pack  = ($urandom_range(0, 3) == 0);
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter MIN_YLW, default 3: minimum legal yellow duration, in ptick pulses (range 1..255).
REQ-002 Parameter WDOG, default 1000: ptick count with no lamp-state change that raises a stall fault (range 1..65535).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 pclr  in  1  reset, asynchronous, active-high.
REQ-005 pgrn1, pylw1, pred1  in  1 each  road-1 lamp drives; active-high, synchronous to clock.
REQ-006 pgrn2, pylw2, pred2  in  1 each  road-2 lamp drives; active-high, synchronous to clock.
REQ-007 ptick  in  1  one-cycle timebase strobe.
REQ-008 ptest  in  1  test mode; suppresses timing checks.
REQ-009 pack  in  1  fault acknowledge.
REQ-010 pfcode  out  5  sticky fault bits, registered: [0] conflict, [1] invalid lamp, [2] sequence, [3] short yellow, [4] stall.
REQ-011 pfault  out  1  OR of pfcode, registered.
REQ-012 pflash  out  1  flash-mode request to the controller; equals pfault.
REQ-013 pnfault  out  8  saturating count of fault-set events.

Function
REQ-014 Each road's lamp triple SHALL decode as follows; any other combination is INVALID.
- {g,y,r} = 100 -> GRN
- 010 -> YLW
- 001 -> RED
REQ-015 The per-road tracked state SHALL be one of RED, GRN or YLW.
REQ-016 The only legal tracked-state transitions SHALL be RED->GRN, GRN->YLW and YLW->RED; holding the current state is legal.
REQ-017 Invalid lamp: if either road decodes INVALID at an edge, pfcode[1] SHALL set at that edge, and that road's tracked state SHALL hold.
REQ-018 Conflict: if both roads decode non-RED valid states (GRN or YLW) at the same edge, pfcode[0] SHALL set at that edge.
REQ-019 Sequence: a valid decode that differs from the tracked state by an illegal transition SHALL set pfcode[2]; the tracked state SHALL still update to the decode.
REQ-020 Yellow timer: an 8-bit counter per road SHALL clear on entry to YLW and increment (saturating at 255) on each ptick while in YLW.
REQ-021 Short yellow: on a YLW->RED transition with yellow count < MIN_YLW and ptest=0, pfcode[3] SHALL set.
REQ-022 Watchdog: a 16-bit counter SHALL clear on any tracked-state change of either road and otherwise increment (saturating) on each ptick.
REQ-023 Stall: when the watchdog counter equals WDOG and ptest=0, pfcode[4] SHALL set.
REQ-024 While ptest=1, both counters SHALL keep running, but pfcode[3] and pfcode[4] SHALL NOT set.
REQ-025 Latency: a violation sampled at rising edge k SHALL appear on pfcode, pfault and pflash after edge k (in cycle k+1); there is no input pipeline stage.
REQ-026 pfcode bits SHALL be sticky until acknowledged.
REQ-027 pack=1 at an edge SHALL clear each pfcode bit whose set condition is not true at that same edge.
REQ-028 A simultaneous set condition and pack SHALL leave the bit set (set wins).
REQ-029 pnfault SHALL increment by 1 at each edge where at least one pfcode bit goes 0->1, regardless of how many bits set; it SHALL saturate at 255 and is not cleared by pack.
REQ-030 Arming: on the first edge after pclr deasserts, tracked states SHALL load from the valid decodes without a sequence check; conflict and invalid checks SHALL apply on that edge.

Reset
REQ-031 While pclr=1, the following SHALL hold immediately, independent of clock: tracked states = RED, all counters = 0, pfcode = 0, pfault = 0, pflash = 0, pnfault = 0, arming pending.
REQ-032 pclr asserted mid-yellow or with faults latched SHALL discard all history; there are no retained faults.

Verification
REQ-033 Legal cycle, MIN_YLW=3: road1 R->G->Y (4 ticks)->R, road2 mirrored, ptest=0 -> pfcode stays 0, pnfault=0.
REQ-034 Drive pgrn1=1 and pgrn2=1 at edge k -> pfcode=00001 and pflash=1 in cycle k+1, pnfault=1; hold 10 cycles -> pnfault still 1.
REQ-035 Road1 Y->R after 2 ticks with MIN_YLW=3 -> pfcode[3]=1; repeat with ptest=1 -> no fault.
REQ-036 Road1 G->R directly -> pfcode[2]=1; pack while pgrn1=pylw1=1 (invalid) -> bit2 clears, bit1 stays 1.
REQ-037 WDOG=5, lamps frozen, ptick every cycle -> pfcode[4] sets after the 5th tick; pack with ptick held low -> cleared; 255 further faults -> pnfault=255.
REQ-038 Assert pclr asynchronously between edges with pfcode=11111 -> outputs 0 before the next edge; first post-reset edge with road1=GRN -> no sequence fault.
